// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with a line-refill FSM (IDLE/FILL/DONE).
// Define ICACHE_STATS_EN to add the Hit_Count_OUT / Miss_Count_OUT statistics counters.
module icache_dm #(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Addr_IN,
  output logic [31:0] Instr_OUT,
  output logic        Hit_OUT,
  input  logic        Flush_IN,
  output logic        Mem_Req_OUT,
  output logic [31:0] Mem_Addr_OUT,
  input  logic        Mem_Valid_IN,
  input  logic [31:0] Mem_Data_IN
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] Hit_Count_OUT,
  output logic [31:0] Miss_Count_OUT
`endif
);

  localparam int OW = $clog2(WORDS_PER_LINE);
  localparam int IW = $clog2(LINES);
  localparam int TW = 32 - IW - OW - 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [OW-1:0]   beat_q;
  logic [31:0]     line_base_q;
  logic            flush_seen_q;
  logic [LINES-1:0] valid_q;

  logic [TW-1:0]   tag_mem  [LINES];
  logic [31:0]     data_mem [LINES][WORDS_PER_LINE];

  logic [IW-1:0]   addr_idx;
  logic [OW-1:0]   addr_off;
  logic [TW-1:0]   addr_tag;
  logic [IW-1:0]   fill_idx;
  logic            lookup_hit;
  logic            last_beat;
  logic            beat_fire;
  logic            fill_done;
  logic            start_fill;
  logic            unused_addr_bits;

  assign addr_off         = Addr_IN[OW+1:2];
  assign addr_idx         = Addr_IN[IW+OW+1:OW+2];
  assign addr_tag         = Addr_IN[31:IW+OW+2];
  assign fill_idx         = line_base_q[IW+OW+1:OW+2];
  assign unused_addr_bits = ^Addr_IN[1:0];

  assign lookup_hit = valid_q[addr_idx] && (tag_mem[addr_idx] == addr_tag);
  assign last_beat  = (beat_q == OW'(WORDS_PER_LINE - 1));
  assign beat_fire  = (state_q == FILL) && Mem_Valid_IN;
  assign fill_done  = beat_fire && last_beat;
  assign start_fill = (state_q == IDLE) && (state_d == FILL);

  assign Hit_OUT      = (state_q == IDLE) && lookup_hit;
  assign Instr_OUT    = Hit_OUT ? data_mem[addr_idx][addr_off] : '0;
  assign Mem_Req_OUT  = (state_q == FILL);
  // Beat offset is OR'd in because the latched base has its word/byte bits zeroed.
  assign Mem_Addr_OUT = (state_q == FILL) ? (line_base_q | 32'({beat_q, 2'b00})) : '0;

  // NOTE: every combinational output gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!Flush_IN && !lookup_hit) state_d = FILL;
      FILL:    if (fill_done) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      line_base_q  <= '0;
      flush_seen_q <= 1'b0;
      valid_q      <= '0;
    end else begin
      state_q <= state_d;

      if (start_fill) begin
        line_base_q  <= {Addr_IN[31:OW+2], {(OW+2){1'b0}}};
        beat_q       <= '0;
        flush_seen_q <= 1'b0;
      end else if (beat_fire) begin
        beat_q <= beat_q + OW'(1);
      end

      // A flush during the refill must keep the line invalid when it completes.
      if (Flush_IN && (state_q == FILL)) flush_seen_q <= 1'b1;

      if (Flush_IN) begin
        valid_q <= '0;
      end else if (fill_done && !flush_seen_q) begin
        valid_q[fill_idx] <= 1'b1;
      end
    end
  end

  // NOTE: tag and data arrays carry no reset; valid bits alone decide whether their contents are used.
  always_ff @(posedge CLK) begin
    if (beat_fire) data_mem[fill_idx][beat_q] <= Mem_Data_IN;
    if (fill_done) tag_mem[fill_idx] <= line_base_q[31:IW+OW+2];
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      Hit_Count_OUT  <= '0;
      Miss_Count_OUT <= '0;
    end else begin
      if (Hit_OUT && !Flush_IN) Hit_Count_OUT <= Hit_Count_OUT + 32'd1;
      if (start_fill) Miss_Count_OUT <= Miss_Count_OUT + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: table of per-cycle vectors plus hand sequences for flush and reset.
module tb_icache_dm;

  logic        CLK;
  logic        RESET;
  logic [31:0] Addr_IN;
  logic [31:0] Instr_OUT;
  logic        Hit_OUT;
  logic        Flush_IN;
  logic        Mem_Req_OUT;
  logic [31:0] Mem_Addr_OUT;
  logic        Mem_Valid_IN;
  logic [31:0] Mem_Data_IN;
`ifdef ICACHE_STATS_EN
  logic [31:0] Hit_Count_OUT;
  logic [31:0] Miss_Count_OUT;
`endif

  icache_dm dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .Addr_IN      (Addr_IN),
    .Instr_OUT    (Instr_OUT),
    .Hit_OUT      (Hit_OUT),
    .Flush_IN     (Flush_IN),
    .Mem_Req_OUT  (Mem_Req_OUT),
    .Mem_Addr_OUT (Mem_Addr_OUT),
    .Mem_Valid_IN (Mem_Valid_IN),
    .Mem_Data_IN  (Mem_Data_IN)
`ifdef ICACHE_STATS_EN
    ,
    .Hit_Count_OUT  (Hit_Count_OUT),
    .Miss_Count_OUT (Miss_Count_OUT)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] addr;
    logic        mv;
    logic [31:0] md;
    logic        fl;
    logic        hit;
    logic [31:0] instr;
    logic        req;
    logic [31:0] maddr;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic mv, input logic [31:0] md, input logic fl);
    Addr_IN      = a;
    Mem_Valid_IN = mv;
    Mem_Data_IN  = md;
    Flush_IN     = fl;
  endtask

  task automatic add(input logic [31:0] a, input logic mv, input logic [31:0] md, input logic fl,
                     input logic hit, input logic [31:0] instr, input logic req, input logic [31:0] maddr);
    vec_t v;
    v.addr = a; v.mv = mv; v.md = md; v.fl = fl;
    v.hit = hit; v.instr = instr; v.req = req; v.maddr = maddr;
    vecs.push_back(v);
  endtask

  task automatic check_outs(input string tag, input logic hit, input logic [31:0] instr,
                            input logic req, input logic [31:0] maddr);
    check({tag, " hit"},   32'(Hit_OUT),     32'(hit));
    check({tag, " instr"}, Instr_OUT,        instr);
    check({tag, " req"},   32'(Mem_Req_OUT), 32'(req));
    check({tag, " maddr"}, Mem_Addr_OUT,     maddr);
  endtask

  // Feeds four back-to-back beats starting from the current FILL cycle.
  task automatic feed_line(input logic [31:0] a, input logic [31:0] d0);
    for (int i = 0; i < 4; i++) begin
      drive(a, 1'b1, d0 + 32'(i), 1'b0);
      tick();
    end
    drive(a, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Cold miss and line fill
    add(32'hBFC00000, 0, 32'h0,  0, 0, 32'h0,  0, 32'h0);
    add(32'hBFC00000, 1, 32'h11, 0, 0, 32'h0,  1, 32'hBFC00000);
    add(32'hBFC00000, 1, 32'h22, 0, 0, 32'h0,  1, 32'hBFC00004);
    add(32'hBFC00000, 1, 32'h33, 0, 0, 32'h0,  1, 32'hBFC00008);
    add(32'hBFC00000, 1, 32'h44, 0, 0, 32'h0,  1, 32'hBFC0000C);
    add(32'hBFC00000, 0, 32'h0,  0, 0, 32'h0,  0, 32'h0);
    add(32'hBFC00000, 0, 32'h0,  0, 1, 32'h11, 0, 32'h0);
    add(32'hBFC00008, 0, 32'h0,  0, 1, 32'h33, 0, 32'h0);
    add(32'hBFC0000C, 0, 32'h0,  0, 1, 32'h44, 0, 32'h0);
    add(32'hBFC00004, 0, 32'h0,  0, 1, 32'h22, 0, 32'h0);
    // Conflict at index 0
    add(32'hBFC00100, 0, 32'h0,  0, 0, 32'h0,  0, 32'h0);
    add(32'hBFC00100, 1, 32'hAA, 0, 0, 32'h0,  1, 32'hBFC00100);
    add(32'hBFC00100, 1, 32'hBB, 0, 0, 32'h0,  1, 32'hBFC00104);
    add(32'hBFC00100, 1, 32'hCC, 0, 0, 32'h0,  1, 32'hBFC00108);
    add(32'hBFC00100, 1, 32'hDD, 0, 0, 32'h0,  1, 32'hBFC0010C);
    add(32'hBFC00100, 0, 32'h0,  0, 0, 32'h0,  0, 32'h0);
    add(32'hBFC00100, 0, 32'h0,  0, 1, 32'hAA, 0, 32'h0);
    add(32'hBFC0010C, 0, 32'h0,  0, 1, 32'hDD, 0, 32'h0);
    add(32'hBFC00000, 0, 32'h0,  0, 0, 32'h0,  0, 32'h0);
    // Gapped refill 1,0,0,1,0,1,1 with the PC wandering mid-fill
    add(32'hBFC00000, 1, 32'h1001, 0, 0, 32'h0, 1, 32'hBFC00000);
    add(32'h00000040, 0, 32'h0,    0, 0, 32'h0, 1, 32'hBFC00004);
    add(32'h00000040, 0, 32'h0,    0, 0, 32'h0, 1, 32'hBFC00004);
    add(32'h00000040, 1, 32'h1002, 0, 0, 32'h0, 1, 32'hBFC00004);
    add(32'hBFC00000, 0, 32'h0,    0, 0, 32'h0, 1, 32'hBFC00008);
    add(32'hBFC00000, 1, 32'h1003, 0, 0, 32'h0, 1, 32'hBFC00008);
    add(32'hBFC00000, 1, 32'h1004, 0, 0, 32'h0, 1, 32'hBFC0000C);
    add(32'hBFC00000, 0, 32'h0,    0, 0, 32'h0, 0, 32'h0);
    add(32'hBFC00000, 0, 32'h0,    0, 1, 32'h1001, 0, 32'h0);
    add(32'hBFC0000C, 0, 32'h0,    0, 1, 32'h1004, 0, 32'h0);

    RESET = 1'b0;
    drive(32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    check_outs("reset", 1'b0, 32'h0, 1'b0, 32'h0);
`ifdef ICACHE_STATS_EN
    check("reset hit_count",  Hit_Count_OUT,  32'h0);
    check("reset miss_count", Miss_Count_OUT, 32'h0);
`endif
    tick();
    tick();
    RESET = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].addr, vecs[i].mv, vecs[i].md, vecs[i].fl);
      #1;
      check_outs($sformatf("vec%0d", i), vecs[i].hit, vecs[i].instr, vecs[i].req, vecs[i].maddr);
      tick();
    end

    // Flush in IDLE invalidates the resident line
    drive(32'hBFC00000, 1'b0, 32'h0, 1'b1);
    #1;
    check("flush_idle hit_before", 32'(Hit_OUT), 32'h1);
    tick();
    drive(32'hBFC00000, 1'b0, 32'h0, 1'b0);
    #1;
    check_outs("flush_idle after", 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    check_outs("flush_fill start", 1'b0, 32'h0, 1'b1, 32'hBFC00000);

    // Flush after beat 2 of the refill leaves the line invalid
    drive(32'hBFC00000, 1'b1, 32'h5001, 1'b0); tick();
    drive(32'hBFC00000, 1'b1, 32'h5002, 1'b0); tick();
    drive(32'hBFC00000, 1'b0, 32'h0,    1'b1); tick();
    drive(32'hBFC00000, 1'b1, 32'h5003, 1'b0); tick();
    check("flush_fill beat3 maddr", Mem_Addr_OUT, 32'hBFC0000C);
    drive(32'hBFC00000, 1'b1, 32'h5004, 1'b0); tick();
    drive(32'hBFC00000, 1'b0, 32'h0,    1'b0);
    #1;
    check_outs("flush_fill done", 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    check_outs("flush_fill relookup", 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    check_outs("flush_fill refetch", 1'b0, 32'h0, 1'b1, 32'hBFC00000);
    feed_line(32'hBFC00000, 32'h6001);
    tick();
    check_outs("refetch hit", 1'b1, 32'h6001, 1'b0, 32'h0);

    // Flush beats a same-cycle miss; the miss is re-detected a cycle later
    drive(32'h00000040, 1'b0, 32'h0, 1'b1);
    #1;
    check_outs("prio flush", 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    drive(32'h00000040, 1'b0, 32'h0, 1'b0);
    #1;
    check_outs("prio held_idle", 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    check_outs("prio redetect", 1'b0, 32'h0, 1'b1, 32'h00000040);
    feed_line(32'h00000040, 32'h7001);
    tick();
    drive(32'h00000044, 1'b0, 32'h0, 1'b0);
    #1;
    check_outs("idx4 hit", 1'b1, 32'h7002, 1'b0, 32'h0);

    // Reset asserted mid-FILL abandons the refill immediately
    drive(32'hBFC00000, 1'b0, 32'h0, 1'b0);
    #1;
    check("rst_fill miss", 32'(Hit_OUT), 32'h0);
    tick();
    drive(32'hBFC00000, 1'b1, 32'h8001, 1'b0);
    tick();
    check("rst_fill beat1 maddr", Mem_Addr_OUT, 32'hBFC00004);
    RESET = 1'b0;
    drive(32'hBFC00000, 1'b1, 32'h8002, 1'b0);
    #1;
    check_outs("rst_fill asserted", 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    RESET = 1'b1;
    drive(32'hBFC00000, 1'b0, 32'h0, 1'b0);
    #1;
    check_outs("rst_fill released", 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    check_outs("rst_fill new_miss", 1'b0, 32'h0, 1'b1, 32'hBFC00000);
`ifdef ICACHE_STATS_EN
    check("rst_fill miss_count", Miss_Count_OUT, 32'h1);
    check("rst_fill hit_count",  Hit_Count_OUT,  32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
